mm_bus: RTL
===========

Name: mm_bus

Overview:
- Multi-cycle successor to the memory-access stage of the MIPS pipeline. Sits between EX/MM pipeline registers and the SRAM/bus arbiter.
- Replaces the single-cycle, always-ready SRAM assumption with a req/ack bus handshake, per-byte write enables (SWL/SWR/SB/SH need no read-modify-write), a pipeline stall output, an ack timeout, and exception-flush handling.
- Load results are merged and sign/zero extended, then registered for WB and the bypass mux.

Parameters:
- ACK_TIMEOUT, 255: cycles in BUS without bus_ack before the access is abandoned with bus_err. Legal range 1..65535.
- EN_UNALIGNED, 1: 1 = LWL/LWR/SWL/SWR supported; 0 = those sizes raise alignment_err.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- exception_flush  in  1  kill current/incoming access
- mem_access_type  in  2  `MEM_ACCESS_TYPE_* from defs.v (M2R load, R2M store, else none)
- mem_access_size  in  3  `MEM_ACCESS_LENGTH_* (BYTE, HALF, WORD, LEFT_WORD, RIGHT_WORD)
- mem_access_signed  in  1  sign-extend BYTE/HALF loads
- addr_i  in  32  effective address from EX
- data_i  in  32  store data / old rt value for LWL/LWR / passthrough
- reg_addr_from_ex  in  5  destination register
- stall  out  1  freeze IF..EX while high
- bus_req  out  1  request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  32  addr_i & 32'hfffffffc
- bus_be  out  4  byte enables, bit n = bits [8n+7:8n]
- bus_wdata  out  32  lane-aligned store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  one-cycle completion
- data_o  out  32  registered result to WB/mux
- reg_we_o  out  1  registered write-back enable, one-cycle pulse per completion
- bypass_reg_addr_mm  out  5  registered dest register, valid with reg_we_o
- alignment_err  out  1  combinational, IDLE only
- bus_err  out  1  one-cycle pulse on timeout
- bad_vaddr  out  32  registered addr_i of the last alignment_err or bus_err

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0, counter 0, discard flag 0.
- Access request: start = IDLE && type ∈ {M2R, R2M}.
- alignment_err conditions: HALF && addr[0]; WORD && addr[1:0] != 0; LEFT/RIGHT with EN_UNALIGNED=0; size codes other than the five defined.
  - On alignment_err no bus cycle is issued, stall stays 0, and bad_vaddr <= addr_i.
  - Flush takes precedence over alignment_err, which is masked to 0.
- Non-memory op (type none) in IDLE: data_o <= data_i, reg_we_o <= 1, bypass_reg_addr_mm <= reg_addr_from_ex next cycle.
  - A flush in the same cycle forces reg_we_o <= 0.
- Accept (start, no error, no flush): latch type/size/signed/addr/data/reg_addr; go to BUS next cycle.
- BUS state: bus_req=1. bus_addr, bus_we, bus_be and bus_wdata are taken from latched values and held stable until ack. Counter increments each cycle.
- Write enables and data, with a = addr[1:0]:
  - BYTE: be = 1<<a; wdata = byte replicated ×4.
  - HALF: be = a[1] ? 1100 : 0011; wdata = half replicated ×2.
  - WORD: be = 1111.
  - LEFT (SWL): be = {a==3, a>=2, a>=1, 1}; wdata = data >> ((3-a)*8).
  - RIGHT (SWR): be = {1, a<=2, a<=1, a==0}; wdata = data << (a*8).
- Reads: be = 1111, wdata = 0.
- Load merge on the ack cycle, with ls = (3-a)*8 and rs = a*8:
  - BYTE/HALF: lane select, then sign- or zero-extend.
  - WORD: bus_rdata.
  - LWL: (rdata<<ls) | (data & ~(ones<<ls)).
  - LWR: (rdata>>rs) | (data & ~(ones>>rs)).
- Ack: bus_ack high in BUS completes the access in that cycle.
  - bus_req drops the next cycle; state goes to IDLE and the counter clears.
  - Next cycle: data_o = load result (loads) or data (stores), reg_we_o = 1 for loads, 0 for stores.
- Stall: stall = (start && !alignment_err && !flush) || (BUS && !bus_ack). It therefore falls in the ack cycle, so the pipeline advances in lockstep with data_o.
- Timeout: counter == ACK_TIMEOUT-1 with no ack → bus_err pulse next cycle, bad_vaddr <= latched addr, bus_req dropped, go to IDLE, reg_we_o = 0.
  - Ack arriving in the same cycle wins: normal completion, no bus_err.
- Flush in BUS: the bus cycle is not cancelled; req stays high until ack/timeout. The discard flag is set and the completion then gives reg_we_o = 0 and no bus_err. stall stays asserted until ack.
- Back-to-back: a new access may start the cycle after returning to IDLE. No combinational path from bus_ack to bus_req.

Test Plan:
- LW at 0x100, ack after 3 BUS cycles with rdata 0xDEADBEEF → bus_addr 0x100, be 1111, stall high 4 cycles, then data_o 0xDEADBEEF, reg_we_o 1.
- LB signed at 0x103, rdata 0x80FF1234 → data_o 0xFFFFFF80; LBU → 0x00000080; LH at 0x101 → alignment_err 1, bad_vaddr 0x101, no bus_req.
- SWL at 0x1001, data 0x11223344 → be 0011, wdata 0x00001122; SWR at 0x1001 → be 1110, wdata 0x22334400.
- LWL at 0x1001, rdata 0xAABBCCDD, data_i 0x11223344 → data_o 0xCCDD3344; LWR at 0x1002, same data → 0x1122AABB.
- ACK_TIMEOUT=4, no ack → bus_req 4 cycles, bus_err pulse, bad_vaddr = addr, reg_we_o 0, stall released.
- Flush in 2nd BUS cycle of a load, ack in 3rd → no reg_we_o; rst_n low mid-BUS → all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/mm_bus.sv
// Memory-access stage: req/ack bus master with per-byte enables, load merge
// and extension, pipeline stall, ack timeout and exception-flush handling.
module mm_bus #(
   parameter int unsigned ACK_TIMEOUT  = 255,
   parameter bit          EN_UNALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exception_flush,
   input  logic [1:0]  mem_access_type,
   input  logic [2:0]  mem_access_size,
   input  logic        mem_access_signed,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic [4:0]  reg_addr_from_ex,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic [31:0] data_o,
   output logic        reg_we_o,
   output logic [4:0]  bypass_reg_addr_mm,
   output logic        alignment_err,
   output logic        bus_err,
   output logic [31:0] bad_vaddr
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   localparam logic [1:0] TYPE_M2R = 2'd1;
   localparam logic [1:0] TYPE_R2M = 2'd2;

   localparam logic [2:0] SIZE_BYTE  = 3'd0;
   localparam logic [2:0] SIZE_HALF  = 3'd1;
   localparam logic [2:0] SIZE_WORD  = 3'd2;
   localparam logic [2:0] SIZE_LEFT  = 3'd3;
   localparam logic [2:0] SIZE_RIGHT = 3'd4;

   typedef enum logic {S_IDLE, S_BUS} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              discard_q;

   logic              lat_load;
   logic [2:0]        lat_size;
   logic              lat_signed;
   logic [31:0]       lat_addr;
   logic [31:0]       lat_data;
   logic [4:0]        lat_reg;

   logic              is_load, is_store, start, size_bad, accept;
   logic              in_bus, timeout, done, kill;

   // Request decode, stall and next state
   always_comb begin
      state_d       = state_q;
      is_load       = (mem_access_type == TYPE_M2R);
      is_store      = (mem_access_type == TYPE_R2M);
      start         = (state_q == S_IDLE) && (is_load || is_store);
      size_bad      = 1'b1;
      case (mem_access_size)
         SIZE_BYTE:             size_bad = 1'b0;
         SIZE_HALF:             size_bad = addr_i[0];
         SIZE_WORD:             size_bad = (addr_i[1:0] != 2'b00);
         SIZE_LEFT, SIZE_RIGHT: size_bad = !EN_UNALIGNED;
         default:               size_bad = 1'b1;
      endcase
      alignment_err = start && size_bad && !exception_flush;
      accept        = start && !size_bad && !exception_flush;
      in_bus        = (state_q == S_BUS);
      timeout       = in_bus && !bus_ack && (cnt_q == CNT_LAST);
      done          = in_bus && (bus_ack || timeout);
      kill          = discard_q || exception_flush;
      stall         = accept || (in_bus && !bus_ack);
      case (state_q)
         S_IDLE:  if (accept) state_d = S_BUS;
         S_BUS:   if (done)   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Store lane placement from the incoming request
   logic [1:0]  a_in, na_in;
   logic [4:0]  ls_in, rs_in;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;

   always_comb begin
      a_in    = addr_i[1:0];
      na_in   = 2'd3 - a_in;
      ls_in   = {na_in, 3'b000};
      rs_in   = {a_in, 3'b000};
      be_c    = 4'hf;
      wdata_c = data_i;
      case (mem_access_size)
         SIZE_BYTE: begin
            be_c    = 4'b0001 << a_in;
            wdata_c = {4{data_i[7:0]}};
         end
         SIZE_HALF: begin
            be_c    = a_in[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{data_i[15:0]}};
         end
         SIZE_LEFT: begin
            be_c    = {a_in == 2'd3, a_in >= 2'd2, a_in >= 2'd1, 1'b1};
            wdata_c = data_i >> ls_in;
         end
         SIZE_RIGHT: begin
            be_c    = {1'b1, a_in <= 2'd2, a_in <= 2'd1, a_in == 2'd0};
            wdata_c = data_i << rs_in;
         end
         default: begin
            be_c    = 4'hf;
            wdata_c = data_i;
         end
      endcase
   end

   // Load merge against the latched request, used on the ack cycle
   logic [1:0]  a_q, na_q;
   logic [4:0]  ls_q, rs_q;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] load_c;

   always_comb begin
      a_q    = lat_addr[1:0];
      na_q   = 2'd3 - a_q;
      ls_q   = {na_q, 3'b000};
      rs_q   = {a_q, 3'b000};
      lane_b = 8'(bus_rdata >> rs_q);
      lane_h = a_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (lat_size)
         SIZE_BYTE:  load_c = {{24{lat_signed & lane_b[7]}}, lane_b};
         SIZE_HALF:  load_c = {{16{lat_signed & lane_h[15]}}, lane_h};
         SIZE_LEFT:  load_c = (bus_rdata << ls_q) | (lat_data & ~(32'hffff_ffff << ls_q));
         SIZE_RIGHT: load_c = (bus_rdata >> rs_q) | (lat_data & ~(32'hffff_ffff >> rs_q));
         default:    load_c = bus_rdata;
      endcase
   end

   // Request latch, bus outputs, write-back and error reporting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_load           <= 1'b0;
         lat_size           <= '0;
         lat_signed         <= 1'b0;
         lat_addr           <= '0;
         lat_data           <= '0;
         lat_reg            <= '0;
         cnt_q              <= '0;
         discard_q          <= 1'b0;
         bus_req            <= 1'b0;
         bus_we             <= 1'b0;
         bus_addr           <= '0;
         bus_be             <= '0;
         bus_wdata          <= '0;
         data_o             <= '0;
         reg_we_o           <= 1'b0;
         bypass_reg_addr_mm <= '0;
         bus_err            <= 1'b0;
         bad_vaddr          <= '0;
      end else begin
         reg_we_o <= 1'b0;
         bus_err  <= 1'b0;
         if (state_q == S_IDLE) begin
            if (accept) begin
               lat_load   <= is_load;
               lat_size   <= mem_access_size;
               lat_signed <= mem_access_signed;
               lat_addr   <= addr_i;
               lat_data   <= data_i;
               lat_reg    <= reg_addr_from_ex;
               cnt_q      <= '0;
               discard_q  <= 1'b0;
               bus_req    <= 1'b1;
               bus_we     <= is_store;
               bus_addr   <= addr_i & 32'hffff_fffc;
               bus_be     <= is_store ? be_c : 4'hf;
               bus_wdata  <= is_store ? wdata_c : 32'h0;
            end else if (alignment_err) begin
               bad_vaddr <= addr_i;
            end else if (!start) begin
               data_o             <= data_i;
               reg_we_o           <= !exception_flush;
               bypass_reg_addr_mm <= reg_addr_from_ex;
            end
         end else if (done) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            if (bus_ack) begin
               data_o             <= lat_load ? load_c : lat_data;
               reg_we_o           <= lat_load && !kill;
               bypass_reg_addr_mm <= lat_reg;
            end else if (!kill) begin
               bus_err   <= 1'b1;
               bad_vaddr <= lat_addr;
            end
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (exception_flush) discard_q <= 1'b1;
         end
      end
   end

endmodule
